edge_frame_writer: RTL
======================

# edge_frame_writer

Sink-side counterpart of the pixel stream that feeds the edge-detection pipeline. It consumes the final `edge_out` / `edge_out_valid` stream from `hysteresis`, packs four 8-bit edge pixels per 32-bit word, buffers the words in a small FIFO, and writes them in raster order to a frame memory through a valid/ready write port. It signals frame completion and any dropped data, which lets the edge image be captured in hardware instead of by bench file I/O.

## Interface
Parameters:
- IMG_W, 512, pixels per output row
- IMG_H, 512, output rows per frame; IMG_W*IMG_H must be a multiple of 4
- ADDR_W, 16, word-address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H/4
- FIFO_DEPTH, 16, word FIFO entries; must be a power of two and at least 2

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock, rising edge
- rstN  in  1  asynchronous active-low reset
- start  in  1  arms capture of one frame; honoured only in IDLE
- base_addr  in  ADDR_W  frame base word address, latched on an accepted start
- edge_in  in  8  edge pixel, driven from hysteresis `edge_out`
- edge_in_valid  in  1  pixel qualifier; there is no backpressure toward the pipeline
- mem_addr  out  ADDR_W  word write address
- mem_wdata  out  32  packed pixels; the first pixel of the group is in [7:0]
- mem_wvalid  out  1  write request
- mem_wready  in  1  memory accepts the write on an edge where it is high together with mem_wvalid
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when the last word has been written
- overflow  out  1  sticky; a packed word was dropped because the FIFO was full

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE
  - edge_in_valid is ignored.
  - When start is high: latch base_addr, clear the pixel counter, byte lane, word index and overflow, then go to RUN.
- RUN
  - Each edge_in_valid edge captures edge_in into byte lane `pix_cnt[1:0]`.
  - On the 4th lane the word {lane3, lane2, lane1, edge_in} is pushed with address base + word_idx. word_idx then increments.
  - When the pixel counter reaches IMG_W*IMG_H, the final word is pushed and the FSM goes to DRAIN.
  - Pixels after the last one are ignored.
- DRAIN
  - No pixel capture.
  - When the FIFO is empty and no write is outstanding, go to DONE.
- DONE
  - Assert frame_done for one cycle, then go to IDLE.
- FIFO
  - Each entry is {addr, data}.
  - The head drives mem_addr, mem_wdata and mem_wvalid directly (show-ahead).
  - Pop happens on mem_wvalid && mem_wready.
- Overflow
  - A push while the FIFO is full and no pop occurs in the same cycle drops that word.
  - overflow is set and stays set.
  - word_idx still advances, so later words keep correct addresses.
  - A push and a pop in the same cycle on a full FIFO is legal and drops nothing.
- Address arithmetic is modulo 2^ADDR_W; base + index wraps silently.
- A start asserted while busy is ignored. It does not restart and does not re-latch base_addr.

## Timing
- Reset values: mem_addr = 0, mem_wdata = 0, mem_wvalid = 0, busy = 0, frame_done = 0, overflow = 0. The FIFO is empty and the FSM is in IDLE.
- Reset asserted mid-frame aborts immediately. Queued words are discarded and no frame_done is produced.
- busy rises on the edge after start is sampled in IDLE.
- Write latency: with the FIFO empty, mem_wvalid rises in the cycle after the edge that captures the 4th pixel of a group.
- mem_addr, mem_wdata and mem_wvalid hold stable while mem_wvalid && !mem_wready.
- mem_wvalid never drops without a handshake, except on reset.
- The FIFO sustains one push and one pop per cycle.
- frame_done is high in the cycle after the DRAIN→DONE edge. busy falls together with frame_done.

## Structure
- Package `edge_writer_pkg` holds:
  - the state enum `ewr_state_t` (IDLE, RUN, DRAIN, DONE)
  - `WORD_BYTES = 4`
  - `PIX_W = 8`
- One sub-module, `sync_fifo`:
  - parameters WIDTH and DEPTH
  - ports push, pop, din, dout, full, empty
  - show-ahead output, same clk and rstN
- The top level contains the FSM, pixel counter, byte-lane packer, word index and overflow flag.

## Test plan
- Reset, then start with base_addr = 0x0100 and IMG_W = IMG_H = 4. Stream the pixels 0x00..0x0F continuously with mem_wready held high → four writes:
  - 0x0100 ← 0x03020100
  - 0x0101 ← 0x07060504
  - 0x0102 ← 0x0B0A0908
  - 0x0103 ← 0x0F0E0D0C
  - then one frame_done pulse, busy = 0 and overflow = 0.
- Same 4×4 frame with gaps in edge_in_valid and mem_wready toggling every cycle → identical write sequence, data stable while stalled, no overflow.
- mem_wready held low with FIFO_DEPTH = 2 on a 4×4 frame → the first two words are retained, the third and fourth are dropped, overflow = 1. After wready is raised, writes occur only at 0x0100 and 0x0101 with correct data, then frame_done.
- edge_in_valid before start, and start pulsed during RUN → pre-start pixels are not captured; the mid-frame start has no effect and the address stays at the original base.
- rstN asserted after 6 pixels → all outputs go to 0 at once. A fresh start then produces a full correct frame starting at lane 0.
- base_addr = 2^ADDR_W − 2 → addresses wrap to 0 and 1.

Source files
------------

// File: rtl/edge_frame_writer_pkg.sv
// Shared types and constants for the edge-image frame writer.
package edge_writer_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned WORD_W     = WORD_BYTES * PIX_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } ewr_state_t;

endpackage

// File: rtl/edge_frame_writer_if.sv
// Frame-memory write port: show-ahead valid/ready word writes.
interface edge_frame_writer_if
  import edge_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
);

  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_wvalid;
  logic              mem_wready;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_wvalid,
    input  mem_wready
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_wvalid,
    output mem_wready
  );

endinterface

// File: rtl/edge_frame_writer_fifo.sv
// Show-ahead synchronous FIFO; dout reads as zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
  assign rd_en = pop && !empty;
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign wr_en = push && (!full || rd_en);
  assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/edge_frame_writer.sv
// Packs the hysteresis edge stream into 32-bit words and writes one frame
// in raster order to frame memory through a buffered valid/ready port.
module edge_frame_writer
  import edge_writer_pkg::*;
#(
  parameter int unsigned IMG_W      = 512,
  parameter int unsigned IMG_H      = 512,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [PIX_W-1:0]    edge_in,
  input  logic                edge_in_valid,
  edge_frame_writer_if.master mem,
  output logic                busy,
  output logic                frame_done,
  output logic                overflow
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned CNT_W = $clog2(NPIX);
  localparam int unsigned ACC_W = (WORD_BYTES - 1) * PIX_W;
  localparam int unsigned ENT_W = ADDR_W + WORD_W;

  ewr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;

  logic              word_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENT_W-1:0]  fifo_din, fifo_dout;

  // Lanes 0..2 shift in from the top, so lane 0 ends up in the low byte.
  assign fifo_din = {base_q + widx_q, edge_in, acc_q};
  assign fifo_pop = mem.mem_wvalid && mem.mem_wready;

  assign mem.mem_wvalid               = !fifo_empty;
  assign {mem.mem_addr, mem.mem_wdata} = fifo_dout;

  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign overflow   = ovf_q;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    widx_d    = widx_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    word_push = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          widx_d  = '0;
          cnt_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (edge_in_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q[1:0] == 2'(WORD_BYTES - 1)) begin
            word_push = 1'b1;
            widx_d    = widx_q + ADDR_W'(1);
          end else begin
            acc_d = {edge_in, acc_q[ACC_W-1:PIX_W]};
          end
          if (cnt_q == CNT_W'(NPIX - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The word index still advances on a dropped word so later addresses stay right.
    if (word_push && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      base_q  <= '0;
      widx_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      widx_q  <= widx_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstN  (rstN),
    .push  (word_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
